axi_gp_arb: RTL

- Two-master to one-slave arbiter that shares a single PL register slave (LED/control bank) between the PS7 M_AXI_GP0 and M_AXI_GP1 ports.
- Sits in pl_m between the PS7 GP ports and the register slave.
- Serialises whole transactions: one write (AW+W→B) or one read (AR→R) at a time.
- Round-robin between masters; restores AXI IDs on responses.
- Single-beat only: LEN=0 is guaranteed by software/driver, so the arbiter always returns RLAST=1.

---
 rtl/axi_gp_pkg.sv | 19 +
 rtl/axi_gp_rr_pick.sv | 15 +
 rtl/axi_gp_arb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_gp_pkg.sv
// Shared constants for the PS7 GP-port arbiter slice: FSM encoding, AXI response codes, default widths.
// No logic; no latency.
// No flow control of its own.
package axi_gp_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 12;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR_REQ = 3'd1;
  localparam logic [2:0] ST_WR_RSP = 3'd2;
  localparam logic [2:0] ST_RD_REQ = 3'd3;
  localparam logic [2:0] ST_RD_RSP = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_gp_rr_pick.sv
// Two-way round-robin picker: grants the sole requester, or the pointed-to one on contention.
// Purely combinational, zero latency.
// No backpressure; the caller decides when a pick is consumed and advances ptr.
module axi_gp_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;
  // On contention follow the pointer, otherwise whichever single bit is set.
  assign gnt_idx   = (&req) ? ptr : req[1];

endmodule

// File: rtl/axi_gp_arb.sv
// Shares one single-beat AXI register slave between PS7 GP0 and GP1, one whole transaction at a time, round-robin.
// Slave-side valid one cycle after a request is first seen in IDLE; shortest transaction is IDLE, REQ, RSP.
// Ungranted master sees all readies/valids low and keeps its request pending; AXI_GP_ARB_GRANT_CNT_EN adds grant counters.
module axi_gp_arb
  import axi_gp_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W
`ifdef AXI_GP_ARB_GRANT_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst,
`ifdef AXI_GP_ARB_GRANT_CNT_EN
  output logic [CNT_W-1:0]    o_gnt_cnt0,
  output logic [CNT_W-1:0]    o_gnt_cnt1,
`endif
  input  logic                i_m0_awvalid,
  input  logic [ADDR_W-1:0]   i_m0_awaddr,
  input  logic [ID_W-1:0]     i_m0_awid,
  output logic                o_m0_awready,
  input  logic                i_m0_wvalid,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  input  logic [DATA_W/8-1:0] i_m0_wstrb,
  output logic                o_m0_wready,
  output logic                o_m0_bvalid,
  output logic [ID_W-1:0]     o_m0_bid,
  output logic [1:0]          o_m0_bresp,
  input  logic                i_m0_bready,
  input  logic                i_m0_arvalid,
  input  logic [ADDR_W-1:0]   i_m0_araddr,
  input  logic [ID_W-1:0]     i_m0_arid,
  output logic                o_m0_arready,
  output logic                o_m0_rvalid,
  output logic [ID_W-1:0]     o_m0_rid,
  output logic [DATA_W-1:0]   o_m0_rdata,
  output logic [1:0]          o_m0_rresp,
  output logic                o_m0_rlast,
  input  logic                i_m0_rready,
  input  logic                i_m1_awvalid,
  input  logic [ADDR_W-1:0]   i_m1_awaddr,
  input  logic [ID_W-1:0]     i_m1_awid,
  output logic                o_m1_awready,
  input  logic                i_m1_wvalid,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_wstrb,
  output logic                o_m1_wready,
  output logic                o_m1_bvalid,
  output logic [ID_W-1:0]     o_m1_bid,
  output logic [1:0]          o_m1_bresp,
  input  logic                i_m1_bready,
  input  logic                i_m1_arvalid,
  input  logic [ADDR_W-1:0]   i_m1_araddr,
  input  logic [ID_W-1:0]     i_m1_arid,
  output logic                o_m1_arready,
  output logic                o_m1_rvalid,
  output logic [ID_W-1:0]     o_m1_rid,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic [1:0]          o_m1_rresp,
  output logic                o_m1_rlast,
  input  logic                i_m1_rready,
  output logic                o_s_awvalid,
  output logic [ADDR_W-1:0]   o_s_awaddr,
  input  logic                i_s_awready,
  output logic                o_s_wvalid,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  input  logic                i_s_wready,
  input  logic                i_s_bvalid,
  input  logic [1:0]          i_s_bresp,
  output logic                o_s_bready,
  output logic                o_s_arvalid,
  output logic [ADDR_W-1:0]   o_s_araddr,
  input  logic                i_s_arready,
  input  logic                i_s_rvalid,
  input  logic [DATA_W-1:0]   i_s_rdata,
  input  logic [1:0]          i_s_rresp,
  output logic                o_s_rready
);

  logic [2:0]      state;
  logic            gnt;
  logic            ptr;
  logic            aw_done;
  logic            w_done;
  logic [ID_W-1:0] saved_id;

  logic [1:0] wr_req;
  logic [1:0] rd_req;
  logic       pick_vld;
  logic       pick_idx;

  // Channel signals of whichever master currently holds the grant.
  logic g_awvalid, g_wvalid, g_arvalid, g_bready, g_rready;
  logic g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign wr_req = {i_m1_awvalid & i_m1_wvalid, i_m0_awvalid & i_m0_wvalid};
  assign rd_req = {i_m1_arvalid, i_m0_arvalid};

  axi_gp_rr_pick u_pick (
    .req       (wr_req | rd_req),
    .ptr       (ptr),
    .gnt_valid (pick_vld),
    .gnt_idx   (pick_idx)
  );

  assign g_awvalid = gnt ? i_m1_awvalid : i_m0_awvalid;
  assign g_wvalid  = gnt ? i_m1_wvalid  : i_m0_wvalid;
  assign g_arvalid = gnt ? i_m1_arvalid : i_m0_arvalid;
  assign g_bready  = gnt ? i_m1_bready  : i_m0_bready;
  assign g_rready  = gnt ? i_m1_rready  : i_m0_rready;

  assign o_s_awaddr = gnt ? i_m1_awaddr : i_m0_awaddr;
  assign o_s_wdata  = gnt ? i_m1_wdata  : i_m0_wdata;
  assign o_s_wstrb  = gnt ? i_m1_wstrb  : i_m0_wstrb;
  assign o_s_araddr = gnt ? i_m1_araddr : i_m0_araddr;

  // Open exactly the channels the current phase owns; everything is closed in IDLE.
  always_comb begin
    o_s_awvalid = 1'b0;
    o_s_wvalid  = 1'b0;
    o_s_bready  = 1'b0;
    o_s_arvalid = 1'b0;
    o_s_rready  = 1'b0;
    g_awready   = 1'b0;
    g_wready    = 1'b0;
    g_bvalid    = 1'b0;
    g_arready   = 1'b0;
    g_rvalid    = 1'b0;
    case (state)
      ST_WR_REQ: begin
        o_s_awvalid = g_awvalid & ~aw_done;
        o_s_wvalid  = g_wvalid & ~w_done;
        g_awready   = i_s_awready & ~aw_done;
        g_wready    = i_s_wready & ~w_done;
      end
      ST_WR_RSP: begin
        g_bvalid   = i_s_bvalid;
        o_s_bready = g_bready;
      end
      ST_RD_REQ: begin
        o_s_arvalid = g_arvalid;
        g_arready   = i_s_arready;
      end
      ST_RD_RSP: begin
        g_rvalid   = i_s_rvalid;
        o_s_rready = g_rready;
      end
      default: ;
    endcase
  end

  assign aw_hs = o_s_awvalid & i_s_awready;
  assign w_hs  = o_s_wvalid & i_s_wready;
  assign b_hs  = i_s_bvalid & o_s_bready;
  assign ar_hs = o_s_arvalid & i_s_arready;
  assign r_hs  = i_s_rvalid & o_s_rready;

  assign o_m0_awready = g_awready & ~gnt;
  assign o_m0_wready  = g_wready & ~gnt;
  assign o_m0_bvalid  = g_bvalid & ~gnt;
  assign o_m0_arready = g_arready & ~gnt;
  assign o_m0_rvalid  = g_rvalid & ~gnt;
  assign o_m1_awready = g_awready & gnt;
  assign o_m1_wready  = g_wready & gnt;
  assign o_m1_bvalid  = g_bvalid & gnt;
  assign o_m1_arready = g_arready & gnt;
  assign o_m1_rvalid  = g_rvalid & gnt;

  // Responses go to both masters' buses; only the granted one sees valid.
  assign o_m0_bid   = saved_id;
  assign o_m1_bid   = saved_id;
  assign o_m0_rid   = saved_id;
  assign o_m1_rid   = saved_id;
  assign o_m0_bresp = g_bvalid ? i_s_bresp : RESP_OKAY;
  assign o_m1_bresp = g_bvalid ? i_s_bresp : RESP_OKAY;
  assign o_m0_rresp = g_rvalid ? i_s_rresp : RESP_OKAY;
  assign o_m1_rresp = g_rvalid ? i_s_rresp : RESP_OKAY;
  assign o_m0_rdata = i_s_rdata;
  assign o_m1_rdata = i_s_rdata;
  // Bursts never happen on this slave, so every beat is the last.
  assign o_m0_rlast = 1'b1;
  assign o_m1_rlast = 1'b1;

  // Transaction sequencer: grant in IDLE, finish request phase, wait for the response, hand priority over.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      gnt      <= 1'b0;
      ptr      <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      saved_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt <= pick_idx;
            if (wr_req[pick_idx]) begin
              state    <= ST_WR_REQ;
              saved_id <= pick_idx ? i_m1_awid : i_m0_awid;
            end else begin
              state    <= ST_RD_REQ;
              saved_id <= pick_idx ? i_m1_arid : i_m0_arid;
            end
          end
        end
        ST_WR_REQ: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state   <= ST_WR_RSP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
          end
        end
        ST_WR_RSP: begin
          if (b_hs) begin
            ptr   <= ~gnt;
            state <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (ar_hs) state <= ST_RD_RSP;
        end
        ST_RD_RSP: begin
          if (r_hs) begin
            ptr   <= ~gnt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXI_GP_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  // Count IDLE grants per master, sticking at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (state == ST_IDLE && pick_vld) begin
      if (!pick_idx && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (pick_idx && gnt_cnt1 != '1)  gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end

  assign o_gnt_cnt0 = gnt_cnt0;
  assign o_gnt_cnt1 = gnt_cnt1;
`endif

endmodule
